alarm_key_entry: RTL and testbench

- Keypad entry front-end for the alarm clock.
- Collects four BCD digits into a shift buffer and validates the entry.
- On ALARM drives the new_alarm_* digits plus a one-cycle load_new_alarm strobe into the alarm time register; on TIME drives load_new_time toward the time counter.
- Handles digit counting, an idle timeout and error signalling, so downstream registers only ever see complete entries.

---
 rtl/alarm_key_pkg.sv | 23 ++
 rtl/alarm_key_shift.sv | 57 +++++
 rtl/alarm_key_entry.sv | 168 ++++++++++++++++
 tb/tb_alarm_key_entry.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_key_pkg.sv
// ---------------------------------------------------------------------------
// alarm_key_pkg
// Shared definitions for the alarm-clock keypad entry front-end:
//   - state_e     : entry FSM state encoding (IDLE, ENTRY, FULL)
//   - KEY_ALARM   : key code that commits the buffer to the alarm register
//   - KEY_TIME    : key code that commits the buffer to the time counter
//   - NUM_DIGITS  : number of BCD digits in a complete entry
//   - DIGIT_W     : width of one BCD digit
// ---------------------------------------------------------------------------
package alarm_key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [3:0] KEY_ALARM  = 4'hA;
    localparam logic [3:0] KEY_TIME   = 4'hB;
    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 4;

endpackage

// File: rtl/alarm_key_shift.sv
// ---------------------------------------------------------------------------
// alarm_key_shift
// Four-digit BCD shift buffer for keypad entry.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset, clears all digits
//   clear       in   clear all digits (highest priority after reset)
//   load_first  in   start a new entry: buffer becomes {0,0,0,digit_in}
//   shift_en    in   shift digits one place toward the MS end, digit_in enters
//   digit_in    in   BCD digit presented with load_first / shift_en
//   digits_out  out  packed buffer, digit 3 (hours tens) in the top nibble
// ---------------------------------------------------------------------------
module alarm_key_shift
    import alarm_key_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            load_first,
    input  logic                            shift_en,
    input  logic [DIGIT_W-1:0]              digit_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits_out
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] digit_reg;

            if (gi == 0) begin : g_lsd
                // Least-significant digit always takes the new key.
                always_ff @(posedge clock) begin
                    if (reset || clear) begin
                        digit_reg <= '0;
                    end else if (load_first || shift_en) begin
                        digit_reg <= digit_in;
                    end
                end
            end else begin : g_upper
                // Upper digits are zeroed on a fresh entry so nothing from
                // the previous entry survives, otherwise take the lower digit.
                always_ff @(posedge clock) begin
                    if (reset || clear) begin
                        digit_reg <= '0;
                    end else if (load_first) begin
                        digit_reg <= '0;
                    end else if (shift_en) begin
                        digit_reg <= digits_out[(gi-1)*DIGIT_W +: DIGIT_W];
                    end
                end
            end

            assign digits_out[gi*DIGIT_W +: DIGIT_W] = digit_reg;
        end
    endgenerate

endmodule

// File: rtl/alarm_key_entry.sv
// ---------------------------------------------------------------------------
// alarm_key_entry
// Keypad entry front-end for the alarm clock. Collects four BCD digits,
// then commits them on ALARM or TIME, with an idle timeout and error pulse.
// Configuration macro: KEY_VALIDATE_EN -- when defined, a full entry must be
// a legal 24h time (HH 00-23, MM 00-59) or the command is rejected.
// Ports:
//   clock             in   system clock
//   reset             in   synchronous active-high reset
//   one_second        in   one-cycle tick per second
//   key_valid         in   one-cycle key strobe
//   key_code [3:0]    in   0-9 digit, A = ALARM, B = TIME, C-F ignored
//   new_alarm_ms_hr   out  buffer digit 3 (hours tens)
//   new_alarm_ls_hr   out  buffer digit 2 (hours units)
//   new_alarm_ms_min  out  buffer digit 1 (minutes tens)
//   new_alarm_ls_min  out  buffer digit 0 (minutes units)
//   load_new_alarm    out  one-cycle alarm register load strobe
//   load_new_time     out  one-cycle time counter load strobe
//   show_new_time     out  high while an entry is in progress
//   entry_error       out  one-cycle pulse on rejected command or timeout
// ---------------------------------------------------------------------------
module alarm_key_entry
    import alarm_key_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       entry_error
);

    state_e                          state_reg;
    logic [2:0]                      digit_cnt_reg;
    logic [3:0]                      timeout_cnt_reg;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits;

    logic key_digit;
    logic key_cmd;
    logic key_hit;
    logic timeout_hit;
    logic entry_ok;
    logic buf_clear;
    logic buf_load_first;
    logic buf_shift;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_cmd   = key_valid && (key_code == KEY_ALARM || key_code == KEY_TIME);
    // Codes C-F are not keys at all: they neither reset the timeout nor
    // swallow a coincident tick.
    assign key_hit   = key_digit || key_cmd;

    // A tick coinciding with a real key is discarded.
    assign timeout_hit = one_second && !key_hit && (state_reg != IDLE)
                         && (timeout_cnt_reg == 4'(TIMEOUT_SEC - 1));

    assign new_alarm_ms_hr  = digits[15:12];
    assign new_alarm_ls_hr  = digits[11:8];
    assign new_alarm_ms_min = digits[7:4];
    assign new_alarm_ls_min = digits[3:0];

`ifdef KEY_VALIDATE_EN
    assign entry_ok = (new_alarm_ms_hr <= 4'd2)
                   && (new_alarm_ls_hr <= 4'd9)
                   && !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3))
                   && (new_alarm_ms_min <= 4'd5)
                   && (new_alarm_ls_min <= 4'd9);
`else
    assign entry_ok = 1'b1;
`endif

    assign buf_load_first = key_digit && (state_reg == IDLE);
    assign buf_shift      = key_digit && (state_reg == ENTRY);
    // Buffer is wiped on any abandoned entry; a successful commit keeps it.
    assign buf_clear      = (key_cmd && (state_reg == ENTRY))
                         || (key_cmd && (state_reg == FULL) && !entry_ok)
                         || timeout_hit;

    alarm_key_shift u_shift (
        .clock      (clock),
        .reset      (reset),
        .clear      (buf_clear),
        .load_first (buf_load_first),
        .shift_en   (buf_shift),
        .digit_in   (key_code),
        .digits_out (digits)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            digit_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            load_new_alarm  <= 1'b0;
            load_new_time   <= 1'b0;
            show_new_time   <= 1'b0;
            entry_error     <= 1'b0;
        end else begin
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_error    <= 1'b0;

            if (key_hit || timeout_hit || state_reg == IDLE) begin
                timeout_cnt_reg <= '0;
            end else if (one_second) begin
                timeout_cnt_reg <= timeout_cnt_reg + 4'd1;
            end

            // show_new_time is updated alongside every state change so it
            // always mirrors "state is ENTRY or FULL".
            case (state_reg)
                IDLE: begin
                    if (key_digit) begin
                        state_reg     <= ENTRY;
                        digit_cnt_reg <= 3'd1;
                        show_new_time <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (key_digit) begin
                        digit_cnt_reg <= digit_cnt_reg + 3'd1;
                        if (digit_cnt_reg == 3'(NUM_DIGITS - 1)) begin
                            state_reg <= FULL;
                        end
                    end else if (key_cmd || timeout_hit) begin
                        entry_error   <= 1'b1;
                        state_reg     <= IDLE;
                        digit_cnt_reg <= '0;
                        show_new_time <= 1'b0;
                    end
                end
                FULL: begin
                    if (key_cmd) begin
                        if (entry_ok) begin
                            load_new_alarm <= (key_code == KEY_ALARM);
                            load_new_time  <= (key_code == KEY_TIME);
                        end else begin
                            entry_error <= 1'b1;
                        end
                        state_reg     <= IDLE;
                        digit_cnt_reg <= '0;
                        show_new_time <= 1'b0;
                    end else if (timeout_hit) begin
                        entry_error   <= 1'b1;
                        state_reg     <= IDLE;
                        digit_cnt_reg <= '0;
                        show_new_time <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    digit_cnt_reg <= '0;
                    show_new_time <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_key_entry.sv
// ---------------------------------------------------------------------------
// tb_alarm_key_entry
// Table-driven bench for alarm_key_entry: each row drives one clock cycle of
// inputs and gives the expected outputs right after that edge. Timeout
// corner cases are driven as hand-written loops.
// Expected flags are packed {load_new_alarm, load_new_time, show_new_time,
// entry_error}; expected buffer is {ms_hr, ls_hr, ms_min, ls_min}.
// ---------------------------------------------------------------------------
module tb_alarm_key_entry;

    logic       clock;
    logic       reset;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] new_alarm_ms_hr;
    logic [3:0] new_alarm_ls_hr;
    logic [3:0] new_alarm_ms_min;
    logic [3:0] new_alarm_ls_min;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       show_new_time;
    logic       entry_error;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  kc;
        logic        tick;
        logic [15:0] exp_buf;
        logic [3:0]  exp_flags;
        string       name;
    } vec_t;

    vec_t vecs[$];

    alarm_key_entry #(.TIMEOUT_SEC(10)) dut (
        .clock            (clock),
        .reset            (reset),
        .one_second       (one_second),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .new_alarm_ms_hr  (new_alarm_ms_hr),
        .new_alarm_ls_hr  (new_alarm_ls_hr),
        .new_alarm_ms_min (new_alarm_ms_min),
        .new_alarm_ls_min (new_alarm_ls_min),
        .load_new_alarm   (load_new_alarm),
        .load_new_time    (load_new_time),
        .show_new_time    (show_new_time),
        .entry_error      (entry_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic r, input logic kv, input logic [3:0] kc,
                       input logic tick, input logic [15:0] eb,
                       input logic [3:0] ef, input string nm);
        vec_t v;
        v.rst = r; v.kv = kv; v.kc = kc; v.tick = tick;
        v.exp_buf = eb; v.exp_flags = ef; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic kv, input logic [3:0] kc,
                        input logic tick, input logic [15:0] eb,
                        input logic [3:0] ef, input string nm);
        logic [15:0] act_buf;
        logic [3:0]  act_flags;
        @(negedge clock);
        reset      = r;
        key_valid  = kv;
        key_code   = kc;
        one_second = tick;
        @(posedge clock);
        #1;
        act_buf   = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
        act_flags = {load_new_alarm, load_new_time, show_new_time, entry_error};
        n_compared++;
        if (act_buf !== eb || act_flags !== ef) begin
            n_mismatched++;
            $display("FAIL %s: got buf=%h flags=%b, expected buf=%h flags=%b",
                     nm, act_buf, act_flags, eb, ef);
        end else begin
            $display("ok   %s: buf=%h flags=%b", nm, act_buf, act_flags);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        one_second = 1'b0;

        // rst kv code tick  exp_buf   flags(la,lt,show,err)
        add(1, 0, 4'h0, 0, 16'h0000, 4'b0000, "reset");
        add(0, 0, 4'h0, 0, 16'h0000, 4'b0000, "idle_after_reset");
        // 0,7,3,0 + ALARM
        add(0, 1, 4'h0, 0, 16'h0000, 4'b0010, "a_key0");
        add(0, 1, 4'h7, 0, 16'h0007, 4'b0010, "a_key7");
        add(0, 1, 4'h3, 0, 16'h0073, 4'b0010, "a_key3");
        add(0, 1, 4'h0, 0, 16'h0730, 4'b0010, "a_key0_full");
        add(0, 1, 4'hA, 0, 16'h0730, 4'b1000, "a_alarm_load");
        add(0, 0, 4'h0, 0, 16'h0730, 4'b0000, "a_strobe_gone");
        // 1,2 + ALARM -> error
        add(0, 1, 4'h1, 0, 16'h0001, 4'b0010, "b_key1");
        add(0, 1, 4'h2, 0, 16'h0012, 4'b0010, "b_key2");
        add(0, 1, 4'hA, 0, 16'h0000, 4'b0001, "b_short_alarm_err");
        add(0, 0, 4'h0, 0, 16'h0000, 4'b0000, "b_err_gone");
        // 2,4,0,0 + ALARM
        add(0, 1, 4'h2, 0, 16'h0002, 4'b0010, "c_key2");
        add(0, 1, 4'h4, 0, 16'h0024, 4'b0010, "c_key4");
        add(0, 1, 4'h0, 0, 16'h0240, 4'b0010, "c_key0");
        add(0, 1, 4'h0, 0, 16'h2400, 4'b0010, "c_key0_full");
`ifdef KEY_VALIDATE_EN
        add(0, 1, 4'hA, 0, 16'h0000, 4'b0001, "c_2400_rejected");
        add(0, 0, 4'h0, 0, 16'h0000, 4'b0000, "c_idle");
`else
        add(0, 1, 4'hA, 0, 16'h2400, 4'b1000, "c_2400_loaded");
        add(0, 0, 4'h0, 0, 16'h2400, 4'b0000, "c_idle");
`endif
        // 1,5,4,5,9 + TIME: fifth digit ignored
        add(0, 1, 4'h1, 0, 16'h0001, 4'b0010, "d_key1");
        add(0, 1, 4'h5, 0, 16'h0015, 4'b0010, "d_key5");
        add(0, 1, 4'h4, 0, 16'h0154, 4'b0010, "d_key4");
        add(0, 1, 4'h5, 0, 16'h1545, 4'b0010, "d_key5_full");
        add(0, 1, 4'h9, 0, 16'h1545, 4'b0010, "d_key9_ignored");
        add(0, 1, 4'hB, 0, 16'h1545, 4'b0100, "d_time_load");
        add(0, 0, 4'h0, 0, 16'h1545, 4'b0000, "d_strobe_gone");
        // commands in IDLE and codes C-F are ignored
        add(0, 1, 4'hA, 0, 16'h1545, 4'b0000, "e_alarm_in_idle");
        add(0, 1, 4'hC, 0, 16'h1545, 4'b0000, "e_codeC_in_idle");
        add(0, 1, 4'h8, 0, 16'h0008, 4'b0010, "e_first_digit_discards");
        add(0, 1, 4'hD, 0, 16'h0008, 4'b0010, "e_codeD_in_entry");
        // 0,6 then reset mid-entry
        add(0, 1, 4'h0, 0, 16'h0080, 4'b0010, "f_key0");
        add(0, 1, 4'h6, 0, 16'h0806, 4'b0010, "f_key6");
        add(1, 0, 4'h0, 0, 16'h0000, 4'b0000, "f_reset_mid_entry");
        add(0, 1, 4'hA, 0, 16'h0000, 4'b0000, "f_alarm_after_reset");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].kv, vecs[i].kc, vecs[i].tick,
                 vecs[i].exp_buf, vecs[i].exp_flags, vecs[i].name);
        end

        // Ticks in IDLE must not pre-load the timeout counter.
        for (int i = 0; i < 5; i++)
            step(0, 0, 4'h0, 1, 16'h0000, 4'b0000, "g_idle_tick");

        // Key 3 then 10 ticks: error on the 10th.
        step(0, 1, 4'h3, 0, 16'h0003, 4'b0010, "g_key3");
        for (int i = 1; i <= 9; i++)
            step(0, 0, 4'h0, 1, 16'h0003, 4'b0010, "g_tick_pending");
        step(0, 0, 4'h0, 1, 16'h0000, 4'b0001, "g_tick10_timeout");
        step(0, 0, 4'h0, 0, 16'h0000, 4'b0000, "g_timeout_err_gone");

        // Key arriving with tick 10: tick discarded, counter restarts.
        step(0, 1, 4'h3, 0, 16'h0003, 4'b0010, "h_key3");
        for (int i = 1; i <= 9; i++)
            step(0, 0, 4'h0, 1, 16'h0003, 4'b0010, "h_tick_pending");
        step(0, 1, 4'h4, 1, 16'h0034, 4'b0010, "h_key_with_tick10");
        for (int i = 1; i <= 9; i++)
            step(0, 0, 4'h0, 1, 16'h0034, 4'b0010, "h_tick_after_key");
        step(0, 0, 4'h0, 1, 16'h0000, 4'b0001, "h_second_timeout");
        step(0, 0, 4'h0, 0, 16'h0000, 4'b0000, "h_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
